// File: rtl/core_pkg.sv
// Shared encodings for the multi-cycle control sequencer.
package core_pkg;

  localparam int unsigned ST_W   = 3;
  localparam int unsigned CODE_W = 4;

  typedef logic [ST_W-1:0]   state_t;
  typedef logic [CODE_W-1:0] code_t;

  // Sequencer state encoding (also exported on state_o for debug)
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_FETCH = 3'd1;
  localparam state_t ST_EXEC  = 3'd2;
  localparam state_t ST_MEM   = 3'd3;
  localparam state_t ST_WB    = 3'd4;
  localparam state_t ST_TRAP  = 3'd5;

  // Trap causes raised by the sequencer itself on memory timeouts
  localparam code_t EXC_INSTR_ACCESS = 4'd1;
  localparam code_t EXC_LOAD_ACCESS  = 4'd5;
  localparam code_t EXC_STORE_ACCESS = 4'd7;

endpackage

// File: rtl/core_seq_exc_prio_arb.sv
// Fixed-priority exception select: lowest enabled channel wins.
module exc_prio_arb
  import core_pkg::*;
#(
  parameter int unsigned NUM_EXC = 5,
  parameter int unsigned XLEN    = 64
) (
  input  logic [NUM_EXC-1:0]        exc_en_vec,
  input  logic [NUM_EXC*CODE_W-1:0] exc_code_vec,
  input  logic [NUM_EXC*XLEN-1:0]   exc_val_vec,
  output logic                      any_exc_c,
  output code_t                     sel_code_c,
  output logic [XLEN-1:0]           sel_val_c
);

  // Scan from channel 0 upward; the first enabled channel is kept
  always_comb begin
    any_exc_c  = 1'b0;
    sel_code_c = '0;
    sel_val_c  = '0;
    for (int unsigned i = 0; i < NUM_EXC; i++) begin
      if (exc_en_vec[i] && !any_exc_c) begin
        any_exc_c  = 1'b1;
        sel_code_c = exc_code_vec[i*CODE_W +: CODE_W];
        sel_val_c  = exc_val_vec[i*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/core_seq.sv
// Multi-cycle fetch/exec/mem/writeback sequencer with trap arbitration.
module core_seq
  import core_pkg::*;
#(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned NUM_EXC  = 5,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [XLEN-1:0]           pc_addr,
  output logic                      imem_req,
  input  logic                      imem_ready,
  output logic                      instr_latch_en,
  input  logic                      is_mem,
  input  logic                      is_store,
  input  logic [XLEN-1:0]           mem_addr,
  output logic                      dmem_req,
  input  logic                      dmem_ready,
  input  logic [NUM_EXC-1:0]        exc_en_vec,
  input  logic [NUM_EXC*CODE_W-1:0] exc_code_vec,
  input  logic [NUM_EXC*XLEN-1:0]   exc_val_vec,
  input  logic                      irq_pending,
  input  logic [CODE_W-1:0]         irq_code,
  input  logic                      mret,
  output logic                      pc_en,
  output logic                      we_regs_en,
  output logic                      we_dmem_en,
  output logic                      we_csr_en,
  output logic                      instr_retired,
  output logic                      trap_taken,
  output logic                      trap_done,
  output logic                      exc_is_irq,
  output logic [CODE_W-1:0]         exc_code,
  output logic [XLEN-1:0]           exc_val,
  output logic [ST_W-1:0]           state_o
);

  // A zero MAX_WAIT disables the timeout but still needs a 1-bit counter
  localparam int unsigned  CNT_W      = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_WAIT);
  localparam bit           TIMEOUT_EN = (MAX_WAIT != 0);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              wait_expired;
  code_t             exc_code_q, exc_code_d;
  logic [XLEN-1:0]   exc_val_q, exc_val_d;
  logic              exc_irq_q, exc_irq_d;

  logic              any_exc;
  code_t             arb_code;
  logic [XLEN-1:0]   arb_val;

  exc_prio_arb #(
    .NUM_EXC (NUM_EXC),
    .XLEN    (XLEN)
  ) u_arb (
    .exc_en_vec   (exc_en_vec),
    .exc_code_vec (exc_code_vec),
    .exc_val_vec  (exc_val_vec),
    .any_exc_c    (any_exc),
    .sel_code_c   (arb_code),
    .sel_val_c    (arb_val)
  );

  // Saturating wait count; expiry is judged on the post-increment value
  assign cnt_inc      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  assign wait_expired = TIMEOUT_EN && (cnt_inc == CNT_LIMIT);

  // State, wait counter and trap-cause registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      exc_code_q <= '0;
      exc_val_q  <= '0;
      exc_irq_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      exc_code_q <= exc_code_d;
      exc_val_q  <= exc_val_d;
      exc_irq_q  <= exc_irq_d;
    end
  end

  // Next-state, wait counting and trap latching
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    exc_code_d = exc_code_q;
    exc_val_d  = exc_val_q;
    exc_irq_d  = exc_irq_q;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem_ready) begin
          state_d = ST_EXEC;
          cnt_d   = '0;
        end else if (wait_expired) begin
          state_d    = ST_TRAP;
          cnt_d      = '0;
          exc_code_d = EXC_INSTR_ACCESS;
          exc_val_d  = pc_addr;
          exc_irq_d  = 1'b0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_EXEC: begin
        if (any_exc) begin
          state_d    = ST_TRAP;
          exc_code_d = arb_code;
          exc_val_d  = arb_val;
          exc_irq_d  = 1'b0;
        end else if (is_mem) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        if (dmem_ready) begin
          state_d = ST_WB;
          cnt_d   = '0;
        end else if (wait_expired) begin
          state_d    = ST_TRAP;
          cnt_d      = '0;
          exc_code_d = is_store ? EXC_STORE_ACCESS : EXC_LOAD_ACCESS;
          exc_val_d  = mem_addr;
          exc_irq_d  = 1'b0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_WB: begin
        if (irq_pending) begin
          state_d    = ST_TRAP;
          exc_code_d = irq_code;
          exc_val_d  = '0;
          exc_irq_d  = 1'b1;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_TRAP: state_d = ST_FETCH;
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobe decode from state and handshake inputs; silenced during reset
  always_comb begin
    imem_req       = 1'b0;
    instr_latch_en = 1'b0;
    dmem_req       = 1'b0;
    pc_en          = 1'b0;
    we_regs_en     = 1'b0;
    we_dmem_en     = 1'b0;
    we_csr_en      = 1'b0;
    instr_retired  = 1'b0;
    trap_taken     = 1'b0;
    trap_done      = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_FETCH: begin
          imem_req       = 1'b1;
          instr_latch_en = imem_ready;
        end
        ST_MEM: begin
          dmem_req   = 1'b1;
          we_dmem_en = dmem_ready & is_store;
        end
        ST_WB: begin
          pc_en         = 1'b1;
          we_regs_en    = 1'b1;
          we_csr_en     = 1'b1;
          instr_retired = 1'b1;
          trap_done     = mret;
        end
        ST_TRAP: begin
          trap_taken = 1'b1;
          pc_en      = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign exc_code   = exc_code_q;
  assign exc_val    = exc_val_q;
  assign exc_is_irq = exc_irq_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_core_seq.sv
// Scenario bench for core_seq: per-cycle state/strobe rows plus a trap scoreboard.
module tb_core_seq;

  localparam int unsigned XLEN = 64;
  localparam int unsigned NEXC = 5;

  localparam logic [2:0] SI = 3'd0, SF = 3'd1, SE = 3'd2, SM = 3'd3, SW = 3'd4, ST = 3'd5;

  localparam logic [9:0] B_IREQ = 10'h200, B_LAT = 10'h100, B_DREQ = 10'h080, B_PC = 10'h040;
  localparam logic [9:0] B_WREG = 10'h020, B_WDM = 10'h010, B_WCSR = 10'h008, B_RET = 10'h004;
  localparam logic [9:0] B_TT = 10'h002, B_TD = 10'h001;
  localparam logic [9:0] K_F  = B_IREQ | B_LAT;
  localparam logic [9:0] K_WB = B_PC | B_WREG | B_WCSR | B_RET;
  localparam logic [9:0] K_TR = B_PC | B_TT;

  localparam logic [63:0] PC_VAL  = 64'h0000_0000_0000_1000;
  localparam logic [63:0] MEM_VAL = 64'h0000_0000_8000_0010;
  localparam logic [63:0] CH2_VAL = 64'hA5A5_0000_0000_0002;

  logic clk = 1'b0;
  logic rst;
  logic [XLEN-1:0] pc_addr, mem_addr;
  logic imem_req, imem_ready, instr_latch_en, is_mem, is_store, dmem_req, dmem_ready;
  logic [NEXC-1:0] exc_en_vec;
  logic [NEXC*4-1:0] exc_code_vec;
  logic [NEXC*XLEN-1:0] exc_val_vec;
  logic irq_pending, mret;
  logic [3:0] irq_code, exc_code;
  logic pc_en, we_regs_en, we_dmem_en, we_csr_en, instr_retired, trap_taken, trap_done, exc_is_irq;
  logic [XLEN-1:0] exc_val;
  logic [2:0] state_o;
  logic [9:0] strb;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic rs, ir, im, ist, dr;
    logic [4:0] exc;
    logic irq, mret;
    logic [2:0] st;
    logic [9:0] strb;
    logic tp, tirq;
    logic [3:0] tcode;
    logic [63:0] tval;
  } row_t;

  typedef struct {
    logic irq;
    logic [3:0] code;
    logic [63:0] val;
  } trap_t;

  trap_t trap_q[$];

  core_seq #(.XLEN(XLEN), .NUM_EXC(NEXC), .MAX_WAIT(3)) dut (
    .clk(clk), .rst(rst), .pc_addr(pc_addr), .imem_req(imem_req), .imem_ready(imem_ready),
    .instr_latch_en(instr_latch_en), .is_mem(is_mem), .is_store(is_store), .mem_addr(mem_addr),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .exc_en_vec(exc_en_vec),
    .exc_code_vec(exc_code_vec), .exc_val_vec(exc_val_vec), .irq_pending(irq_pending),
    .irq_code(irq_code), .mret(mret), .pc_en(pc_en), .we_regs_en(we_regs_en),
    .we_dmem_en(we_dmem_en), .we_csr_en(we_csr_en), .instr_retired(instr_retired),
    .trap_taken(trap_taken), .trap_done(trap_done), .exc_is_irq(exc_is_irq),
    .exc_code(exc_code), .exc_val(exc_val), .state_o(state_o)
  );

  always #5 clk = ~clk;

  assign strb = {imem_req, instr_latch_en, dmem_req, pc_en, we_regs_en, we_dmem_en,
                 we_csr_en, instr_retired, trap_taken, trap_done};

  function automatic row_t mk(logic rs, logic ir, logic im, logic ist, logic dr, logic [4:0] exc,
                              logic irq, logic mr, logic [2:0] st, logic [9:0] sb,
                              logic tp, logic tirq, logic [3:0] tcode, logic [63:0] tval);
    row_t r;
    r.rs = rs; r.ir = ir; r.im = im; r.ist = ist; r.dr = dr; r.exc = exc;
    r.irq = irq; r.mret = mr; r.st = st; r.strb = sb;
    r.tp = tp; r.tirq = tirq; r.tcode = tcode; r.tval = tval;
    return r;
  endfunction

  // Drive one row's inputs; a trap-causing row also books the expected trap
  task automatic apply(input row_t r);
    rst = r.rs; imem_ready = r.ir; is_mem = r.im; is_store = r.ist; dmem_ready = r.dr;
    exc_en_vec = r.exc; irq_pending = r.irq; mret = r.mret;
    if (r.tp) trap_q.push_back('{r.tirq, r.tcode, r.tval});
  endtask

  task automatic test_reset();
    apply(mk(1, 1, 1, 1, 1, 5'b11111, 1, 1, SI, 10'h0, 0, 0, 0, 0));
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    n_total++;
    if (state_o !== SI) $display("FAIL reset_state got %0d exp %0d", state_o, SI); else n_pass++;
    n_total++;
    if (strb !== 10'h0) $display("FAIL reset_strobes got %b exp %b", strb, 10'h0); else n_pass++;
    n_total++;
    if ({exc_is_irq, exc_code, exc_val} !== 69'h0)
      $display("FAIL reset_trap_regs got %0b/%0d/%h exp 0/0/0", exc_is_irq, exc_code, exc_val);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_alu();
    row_t r[$];
    trap_t t;
    r.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, SI, 10'h0, 0, 0, 0, 0));
    for (int k = 0; k < 2; k++) begin
      r.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, SF, K_F,   0, 0, 0, 0));
      r.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, SE, 10'h0, 0, 0, 0, 0));
      r.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, SW, K_WB,  0, 0, 0, 0));
    end
    foreach (r[i]) begin
      apply(r[i]);
      @(negedge clk);
      n_total++;
      if ({state_o, strb} !== {r[i].st, r[i].strb})
        $display("FAIL alu[%0d] state/strb got %0d/%b exp %0d/%b", i, state_o, strb, r[i].st, r[i].strb);
      else n_pass++;
      if (trap_taken === 1'b1) begin
        n_total++;
        if (trap_q.size() == 0) $display("FAIL alu[%0d] trap got taken exp none", i);
        else begin
          t = trap_q.pop_front();
          if ({exc_is_irq, exc_code, exc_val} !== {t.irq, t.code, t.val})
            $display("FAIL alu[%0d] trap got %0b/%0d/%h exp %0b/%0d/%h", i, exc_is_irq, exc_code, exc_val, t.irq, t.code, t.val);
          else n_pass++;
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_store();
    row_t r[$];
    trap_t t;
    r.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, SF, K_F,    0, 0, 0, 0));
    r.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, SE, 10'h0,  0, 0, 0, 0));
    r.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, SM, B_DREQ, 0, 0, 0, 0));
    r.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, SM, B_DREQ, 0, 0, 0, 0));
    r.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0, SM, B_DREQ, 0, 0, 0, 0));
    r.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, SW, K_WB,   0, 0, 0, 0));
    r.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, SF, K_F,    0, 0, 0, 0));
    r.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, SE, 10'h0,  0, 0, 0, 0));
    r.push_back(mk(0, 0, 1, 1, 1, 0, 0, 0, SM, B_DREQ | B_WDM, 0, 0, 0, 0));
    r.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, SW, K_WB,   0, 0, 0, 0));
    foreach (r[i]) begin
      apply(r[i]);
      @(negedge clk);
      n_total++;
      if ({state_o, strb} !== {r[i].st, r[i].strb})
        $display("FAIL ldst[%0d] state/strb got %0d/%b exp %0d/%b", i, state_o, strb, r[i].st, r[i].strb);
      else n_pass++;
      if (trap_taken === 1'b1) begin
        n_total++;
        if (trap_q.size() == 0) $display("FAIL ldst[%0d] trap got taken exp none", i);
        else begin
          t = trap_q.pop_front();
          if ({exc_is_irq, exc_code, exc_val} !== {t.irq, t.code, t.val})
            $display("FAIL ldst[%0d] trap got %0b/%0d/%h exp %0b/%0d/%h", i, exc_is_irq, exc_code, exc_val, t.irq, t.code, t.val);
          else n_pass++;
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeouts();
    row_t r[$];
    trap_t t;
    // instruction fetch never answers: three wait cycles then cause 1
    r.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, SF, B_IREQ, 0, 0, 0, 0));
    r.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, SF, B_IREQ, 0, 0, 0, 0));
    r.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, SF, B_IREQ, 1, 0, 4'd1, PC_VAL));
    r.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, ST, K_TR,   0, 0, 0, 0));
    // store never completes: three MEM cycles then cause 7, no commit
    r.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, SF, K_F,    0, 0, 0, 0));
    r.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, SE, 10'h0,  0, 0, 0, 0));
    r.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, SM, B_DREQ, 0, 0, 0, 0));
    r.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, SM, B_DREQ, 0, 0, 0, 0));
    r.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, SM, B_DREQ, 1, 0, 4'd7, MEM_VAL));
    r.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, ST, K_TR,   0, 0, 0, 0));
    foreach (r[i]) begin
      apply(r[i]);
      @(negedge clk);
      n_total++;
      if ({state_o, strb} !== {r[i].st, r[i].strb})
        $display("FAIL tmo[%0d] state/strb got %0d/%b exp %0d/%b", i, state_o, strb, r[i].st, r[i].strb);
      else n_pass++;
      if (trap_taken === 1'b1) begin
        n_total++;
        if (trap_q.size() == 0) $display("FAIL tmo[%0d] trap got taken exp none", i);
        else begin
          t = trap_q.pop_front();
          if ({exc_is_irq, exc_code, exc_val} !== {t.irq, t.code, t.val})
            $display("FAIL tmo[%0d] trap got %0b/%0d/%h exp %0b/%0d/%h", i, exc_is_irq, exc_code, exc_val, t.irq, t.code, t.val);
          else n_pass++;
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_exc_prio();
    row_t r[$];
    trap_t t;
    irq_code = 4'hB;
    r.push_back(mk(0, 1, 0, 0, 0, 0,        1, 0, SF, K_F,   0, 0, 0, 0));
    r.push_back(mk(0, 0, 0, 0, 0, 5'b10100, 1, 0, SE, 10'h0, 1, 0, 4'd2, CH2_VAL));
    r.push_back(mk(0, 0, 0, 0, 0, 0,        1, 0, ST, K_TR,  0, 0, 0, 0));
    r.push_back(mk(0, 1, 0, 0, 0, 0,        1, 0, SF, K_F,   0, 0, 0, 0));
    r.push_back(mk(0, 0, 0, 0, 0, 0,        1, 0, SE, 10'h0, 0, 0, 0, 0));
    r.push_back(mk(0, 0, 0, 0, 0, 0,        1, 0, SW, K_WB,  1, 1, 4'hB, 64'h0));
    r.push_back(mk(0, 0, 0, 0, 0, 0,        0, 0, ST, K_TR,  0, 0, 0, 0));
    foreach (r[i]) begin
      apply(r[i]);
      @(negedge clk);
      n_total++;
      if ({state_o, strb} !== {r[i].st, r[i].strb})
        $display("FAIL prio[%0d] state/strb got %0d/%b exp %0d/%b", i, state_o, strb, r[i].st, r[i].strb);
      else n_pass++;
      if (trap_taken === 1'b1) begin
        n_total++;
        if (trap_q.size() == 0) $display("FAIL prio[%0d] trap got taken exp none", i);
        else begin
          t = trap_q.pop_front();
          if ({exc_is_irq, exc_code, exc_val} !== {t.irq, t.code, t.val})
            $display("FAIL prio[%0d] trap got %0b/%0d/%h exp %0b/%0d/%h", i, exc_is_irq, exc_code, exc_val, t.irq, t.code, t.val);
          else n_pass++;
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mret_irq();
    row_t r[$];
    trap_t t;
    irq_code = 4'd7;
    r.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, SF, K_F,         0, 0, 0, 0));
    r.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, SE, 10'h0,       0, 0, 0, 0));
    r.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, SW, K_WB | B_TD, 1, 1, 4'd7, 64'h0));
    r.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, ST, K_TR,        0, 0, 0, 0));
    foreach (r[i]) begin
      apply(r[i]);
      @(negedge clk);
      n_total++;
      if ({state_o, strb} !== {r[i].st, r[i].strb})
        $display("FAIL mret[%0d] state/strb got %0d/%b exp %0d/%b", i, state_o, strb, r[i].st, r[i].strb);
      else n_pass++;
      if (trap_taken === 1'b1) begin
        n_total++;
        if (trap_q.size() == 0) $display("FAIL mret[%0d] trap got taken exp none", i);
        else begin
          t = trap_q.pop_front();
          if ({exc_is_irq, exc_code, exc_val} !== {t.irq, t.code, t.val})
            $display("FAIL mret[%0d] trap got %0b/%0d/%h exp %0b/%0d/%h", i, exc_is_irq, exc_code, exc_val, t.irq, t.code, t.val);
          else n_pass++;
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rst_mid_mem();
    row_t r[$];
    trap_t t;
    r.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, SF, K_F,    0, 0, 0, 0));
    r.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, SE, 10'h0,  0, 0, 0, 0));
    r.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, SM, B_DREQ, 0, 0, 0, 0));
    r.push_back(mk(1, 1, 1, 1, 1, 0, 0, 0, SM, 10'h0,  0, 0, 0, 0));
    r.push_back(mk(0, 1, 1, 1, 1, 0, 0, 0, SI, 10'h0,  0, 0, 0, 0));
    r.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, SF, K_F,    0, 0, 0, 0));
    foreach (r[i]) begin
      apply(r[i]);
      @(negedge clk);
      n_total++;
      if ({state_o, strb} !== {r[i].st, r[i].strb})
        $display("FAIL rstmem[%0d] state/strb got %0d/%b exp %0d/%b", i, state_o, strb, r[i].st, r[i].strb);
      else n_pass++;
      if (trap_taken === 1'b1) begin
        n_total++;
        if (trap_q.size() == 0) $display("FAIL rstmem[%0d] trap got taken exp none", i);
        else begin
          t = trap_q.pop_front();
          if ({exc_is_irq, exc_code, exc_val} !== {t.irq, t.code, t.val})
            $display("FAIL rstmem[%0d] trap got %0b/%0d/%h exp %0b/%0d/%h", i, exc_is_irq, exc_code, exc_val, t.irq, t.code, t.val);
          else n_pass++;
        end
      end
      @(posedge clk); #1;
    end
    n_total++;
    if ({exc_is_irq, exc_code, exc_val} !== 69'h0)
      $display("FAIL rstmem_trap_regs got %0b/%0d/%h exp 0/0/0", exc_is_irq, exc_code, exc_val);
    else n_pass++;
  endtask

  initial begin
    pc_addr      = PC_VAL;
    mem_addr     = MEM_VAL;
    irq_code     = 4'h0;
    exc_code_vec = {4'd3, 4'd6, 4'd2, 4'd8, 4'd9};
    for (int i = 0; i < int'(NEXC); i++)
      exc_val_vec[i*XLEN +: XLEN] = 64'hA5A5_0000_0000_0000 + 64'(i);
    test_reset();
    test_alu();
    test_load_store();
    test_timeouts();
    test_exc_prio();
    test_mret_irq();
    test_rst_mid_mem();
    n_total++;
    if (trap_q.size() != 0) $display("FAIL trap_scoreboard got %0d pending exp 0", trap_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/core_seq.md
Name: core_seq

Overview:
- Parametrised multi-cycle control sequencer; successor to the single-cycle core top, which has a permanently enabled PC.
- Sequences each instruction through fetch, execute, memory and writeback, with ready/valid memory handshakes, so imem/dmem may insert wait states.
- Arbitrates NUM_EXC exception sources plus one masked interrupt into a single registered trap request.
- Sits between decoder/csr_top/trap_handler and pc/regfile/dmem, gating all architectural write enables.

Parameters:
- XLEN, 64, datapath and exc_val width.
- NUM_EXC, 5, number of exception source channels; index 0 has highest priority.
- MAX_WAIT, 15, memory wait-cycle limit before an access-fault trap; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- pc_addr  in  XLEN  current PC, used as exc_val on fetch timeout
- imem_req  out  1  fetch request
- imem_ready  in  1  fetch data valid; may be high in the same cycle as imem_req
- instr_latch_en  out  1  one-cycle strobe to capture the fetched instruction
- is_mem / is_store  in  1 / 1  decoded load-or-store / store
- mem_addr  in  XLEN  data address, used as exc_val on data timeout
- dmem_req  out  1  data request
- dmem_ready  in  1  data access complete
- exc_en_vec  in  NUM_EXC  per-source exception valid
- exc_code_vec  in  NUM_EXC*4  packed codes; channel i occupies bits [4i+3:4i]
- exc_val_vec  in  NUM_EXC*XLEN  packed trap values
- irq_pending / irq_code  in  1 / 4  masked interrupt request and its cause
- mret  in  1  decoded MRET
- pc_en  out  1  PC update strobe
- we_regs_en / we_dmem_en / we_csr_en  out  1 each  write qualifiers
- instr_retired  out  1  retire pulse
- trap_taken / trap_done  out  1 / 1  trap entry / MRET return pulses
- exc_is_irq  out  1  trap cause is an interrupt
- exc_code  out  4  registered trap cause
- exc_val  out  XLEN  registered trap value
- state_o  out  3  current state, for debug

Behaviour:
- Reset: synchronous, active-high, checked first every cycle.
  - Reset forces state IDLE, wait counter 0, and exc_code/exc_val/exc_is_irq to 0.
  - All strobe outputs are 0 while rst is high, including reset asserted mid-FETCH or mid-MEM. Any outstanding request is dropped.
- States: IDLE, FETCH, EXEC, MEM, WB, TRAP. All strobes are Moore-decoded from state and inputs, one cycle wide.
- IDLE: one cycle after reset release, then FETCH.
- FETCH: imem_req=1.
  - imem_ready=1: instr_latch_en=1, go to EXEC, clear the counter.
  - Otherwise the counter increments. When the counter equals MAX_WAIT (MAX_WAIT≠0), latch code 1 (instruction access fault) with exc_val=pc_addr, then go to TRAP.
- EXEC: one cycle for decode/ALU to settle.
  - Any exc_en_vec bit set: latch the lowest set index's code and val, exc_is_irq=0, go to TRAP. No write enables assert.
  - Else is_mem: go to MEM.
  - Else: go to WB.
- MEM: dmem_req=1.
  - dmem_ready=1: we_dmem_en=is_store in that cycle, then go to WB.
  - Timeout as in FETCH: code 7 if is_store else 5, exc_val=mem_addr, go to TRAP. No store commits.
- WB: pc_en=1, we_regs_en=1, we_csr_en=1, instr_retired=1; trap_done=mret.
  - irq_pending=1: latch irq_code, exc_val=0, exc_is_irq=1, go to TRAP.
  - Else: go to FETCH.
- TRAP: trap_taken=1 and pc_en=1 (PC loads the vector) for one cycle, then FETCH. exc_code/exc_val hold until the next trap latch.
- Priority:
  - A synchronous exception in EXEC pre-empts the interrupt; the interrupt is sampled only in WB, at the instruction boundary.
  - MRET together with irq_pending in WB: trap_done pulses first, TRAP follows in the next cycle.
- Latency with zero-wait memories: ALU instruction 3 cycles (FETCH, EXEC, WB); load/store 4 cycles.
- Counter: width $clog2(MAX_WAIT+1), saturating; cleared on every FETCH/MEM exit.

Decomposition:
- Package core_pkg holds:
  - state encoding localparams: IDLE=0, FETCH=1, EXEC=2, MEM=3, WB=4, TRAP=5;
  - cause constants: EXC_INSTR_ACCESS=1, EXC_LOAD_ACCESS=5, EXC_STORE_ACCESS=7.
- One sub-module, exc_prio_arb (parametrised NUM_EXC, XLEN): combinational lowest-index select of code and val plus an any_exc flag.

Test Plan:
- ALU instruction with imem_ready tied high → states FETCH, EXEC, WB. instr_retired pulses every 3rd cycle; pc_en high only in WB.
- Load with dmem_ready after 2 wait cycles → 6-cycle instruction; we_dmem_en=0 throughout; we_regs_en pulses once in WB.
- MAX_WAIT=3, store, dmem_ready never asserted → after 3 MEM wait cycles, trap_taken=1 with exc_code=7, exc_val=mem_addr (0x8000_0010). No we_dmem_en, no retire.
- exc_en_vec=5'b10100 in EXEC (codes 2 on ch2, 3 on ch4) → exc_code=2, exc_val=ch2 value; irq_pending=1 at the same time is ignored until a later WB.
- irq_pending=1 with irq_code=7 during WB of an MRET → trap_done in WB, trap_taken next cycle with exc_is_irq=1, exc_code=7.
- rst asserted mid-MEM with dmem_req=1 → next cycle all strobes 0, state_o=IDLE; FETCH on the second cycle after release.
